// File: rtl/and_gate_pkg.sv
// and_gate_pkg: shared constants and helpers for the and_gate block.
//   SKID_DEPTH      - number of result slots (output register + skid register)
//   MAX_WIDTH       - largest operand width the flag helper supports
//   and_reduce_flags - returns {all-ones, any-one} over the low i_width bits
package and_gate_pkg;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned MAX_WIDTH  = 256;

    // Operates on a zero-padded vector so one function serves every WIDTH;
    // bits at or above i_width are ignored.
    function automatic logic [1:0] and_reduce_flags(
        input logic [MAX_WIDTH-1:0] i_value,
        input int unsigned          i_width
    );
        logic w_all;
        logic w_any;
        w_all = 1'b1;
        w_any = 1'b0;
        for (int unsigned k = 0; k < MAX_WIDTH; k++) begin
            if (k < i_width) begin
                w_all = w_all & i_value[k];
                w_any = w_any | i_value[k];
            end
        end
        return {w_all, w_any};
    endfunction

endpackage

// File: rtl/and_gate_skid.sv
// and_gate_skid: generic 2-entry valid/ready skid buffer.
//   clk, rst            - clock, synchronous active-high reset
//   i_valid/o_ready     - upstream handshake (o_ready is registered)
//   i_data              - upstream payload
//   o_valid/i_ready     - downstream handshake
//   o_data              - registered payload, held while stalled
module and_gate_skid
    import and_gate_pkg::*;
#(
    parameter int unsigned DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_ready;

    logic              w_acc;
    logic              w_emit;
    logic              w_out_valid_next;
    logic [DATA_W-1:0] w_out_data_next;
    logic              w_skid_valid_next;
    logic [DATA_W-1:0] w_skid_data_next;
    logic              w_ready_next;

    always_comb begin
        w_acc             = i_valid & r_ready;
        w_emit            = r_out_valid & i_ready;
        w_out_valid_next  = r_out_valid;
        w_out_data_next   = r_out_data;
        w_skid_valid_next = r_skid_valid;
        w_skid_data_next  = r_skid_data;

        if (!r_out_valid || w_emit) begin
            // Output slot frees up this edge. A full skid has priority; an
            // accept cannot coincide with it because r_ready is low then.
            if (r_skid_valid) begin
                w_out_valid_next  = 1'b1;
                w_out_data_next   = r_skid_data;
                w_skid_valid_next = 1'b0;
            end else if (w_acc) begin
                w_out_valid_next = 1'b1;
                w_out_data_next  = i_data;
            end else begin
                // Data is kept so an idle output stays unchanged.
                w_out_valid_next = 1'b0;
            end
        end else if (w_acc) begin
            w_skid_valid_next = 1'b1;
            w_skid_data_next  = i_data;
        end

        // Ready whenever a slot will be free next cycle; since the skid only
        // fills behind a full output register, this equals !skid occupied.
        w_ready_next = (32'(w_out_valid_next) + 32'(w_skid_valid_next)) < SKID_DEPTH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_next;
            r_out_data   <= w_out_data_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_data  <= w_skid_data_next;
            r_ready      <= w_ready_next;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

// File: rtl/and_gate.sv
// and_gate: clocked bitwise AND (C = A & B) with all/any reduction flags,
// fed through a valid/ready input and a registered 2-entry skid output.
//   clk, rst             - clock, synchronous active-high reset
//   A, B                 - WIDTH-bit operands (WIDTH between 1 and MAX_WIDTH)
//   in_valid / in_ready  - operand handshake
//   C, C_all, C_any      - registered result and flags
//   out_valid / out_ready - result handshake
module and_gate
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] C,
    output logic             C_all,
    output logic             C_any,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0]     w_and;
    logic [MAX_WIDTH-1:0] w_and_pad;
    logic [1:0]           w_flags;
    logic [WIDTH+1:0]     w_in_data;
    logic [WIDTH+1:0]     w_out_data;

    always_comb begin
        w_and              = A & B;
        w_and_pad          = '0;
        w_and_pad[WIDTH-1:0] = w_and;
        w_flags            = and_reduce_flags(w_and_pad, WIDTH);
        // Flags travel with the result so they stay aligned through the skid.
        w_in_data          = {w_flags, w_and};
    end

    and_gate_skid #(
        .DATA_W(WIDTH + 2)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_data),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_data)
    );

    assign {C_all, C_any, C} = w_out_data;

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic [7:0] a8, b8, c8;
    logic       iv8, ir8, ca8, cy8, ov8, or8;
    // WIDTH=1 instance
    logic       a1, b1, c1, iv1, ir1, ca1, cy1, ov1, or1;

    and_gate #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(iv8), .in_ready(ir8),
        .C(c8), .C_all(ca8), .C_any(cy8), .out_valid(ov8), .out_ready(or8)
    );

    and_gate #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(iv1), .in_ready(ir1),
        .C(c1), .C_all(ca1), .C_any(cy1), .out_valid(ov1), .out_ready(or1)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] q[$];
    logic [9:0] last_out;
    bit         post_rst;
    int         n_emit;

    // Reference: result packed as {all, any, C}.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] c;
        c = a & b;
        return {c == 8'hFF, c != 8'h00, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of the WIDTH=8 stream, checked against the queue model.
    task automatic cycle8(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic ordy, output logic acc);
        logic emit;
        iv8 = v; a8 = a; b8 = b; or8 = ordy;
        @(negedge clk);
        check("out_valid", 64'(ov8), 64'(q.size() > 0));
        check("in_ready", 64'(ir8), 64'((q.size() < 2) && !post_rst));
        if (q.size() > 0) check("result", 64'({ca8, cy8, c8}), 64'(q[0]));
        else              check("idle_hold", 64'({ca8, cy8, c8}), 64'(last_out));
        acc  = v && ir8;
        emit = ov8 && ordy;
        @(posedge clk); #1;
        if (emit) begin
            last_out = q.pop_front();
            n_emit++;
        end
        if (acc) q.push_back(ref8(a, b));
        post_rst = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; iv8 = 1'b0; or8 = 1'b1; iv1 = 1'b0; or1 = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 64'(ov8), 64'(0));
        check("rst_C", 64'({ca8, cy8, c8}), 64'(0));
        check("rst_in_ready", 64'(ir8), 64'(0));
        check("rst1_out_valid", 64'(ov1), 64'(0));
        check("rst1_in_ready", 64'(ir1), 64'(0));
        q.delete();
        last_out = '0;
        post_rst = 1'b1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       acc;
        logic [7:0] pa[4];
        logic [7:0] pb[4];
        int         idx;
        int         base;
        bit         saw_low;
        int         n_acc;

        rst = 1'b1; a8 = '0; b8 = '0; iv8 = 1'b0; or8 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        n_emit = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // WIDTH=1 truth table
        @(posedge clk); #1;
        check("w1_ready_after_rst", 64'(ir1), 64'(1));
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            a1 = ab[0]; b1 = ab[1]; iv1 = 1'b1;
            @(posedge clk); #1;
            check("w1_C", 64'(c1), 64'(ab[0] & ab[1]));
            check("w1_all", 64'(ca1), 64'(ab[0] & ab[1]));
            check("w1_any", 64'(cy1), 64'(ab[0] & ab[1]));
            check("w1_out_valid", 64'(ov1), 64'(1));
        end
        iv1 = 1'b0;
        post_rst = 1'b0;

        // Directed WIDTH=8 vectors
        cycle8(1'b1, 8'hF0, 8'h3C, 1'b1, acc);
        check("dir_F0_C", 64'(c8), 64'(8'h30));
        check("dir_F0_all", 64'(ca8), 64'(0));
        check("dir_F0_any", 64'(cy8), 64'(1));
        cycle8(1'b1, 8'hFF, 8'hFF, 1'b1, acc);
        check("dir_FF_C", 64'(c8), 64'(8'hFF));
        check("dir_FF_all", 64'(ca8), 64'(1));
        cycle8(1'b1, 8'hAA, 8'h55, 1'b1, acc);
        check("dir_AA_C", 64'(c8), 64'(8'h00));
        check("dir_AA_any", 64'(cy8), 64'(0));
        cycle8(1'b0, 8'h00, 8'h00, 1'b1, acc);

        // Backpressure: 4 pairs, out_ready low for the first cycles
        pa = '{8'h81, 8'hC3, 8'h7E, 8'hFF};
        pb = '{8'hFF, 8'h0F, 8'h3C, 8'h99};
        idx = 0; base = n_emit; saw_low = 1'b0;
        for (int t = 0; t < 40 && (idx < 4 || q.size() > 0); t++) begin
            cycle8(idx < 4, (idx < 4) ? pa[idx] : 8'h00, (idx < 4) ? pb[idx] : 8'h00,
                   t >= 6, acc);
            if (acc) idx++;
            if (t < 6 && !ir8) saw_low = 1'b1;
        end
        check("bp_sent", 64'(idx), 64'(4));
        check("bp_emitted", 64'(n_emit - base), 64'(4));
        check("bp_ready_fell", 64'(saw_low), 64'(1));

        // Continuous stream with out_ready high
        n_acc = 0;
        for (int t = 0; t < 20; t++) begin
            cycle8(1'b1, 8'($urandom), 8'($urandom), 1'b1, acc);
            if (acc) n_acc++;
        end
        check("stream_accepts", 64'(n_acc), 64'(20));

        // Reset with two results buffered
        cycle8(1'b1, 8'h5A, 8'hF3, 1'b0, acc);
        cycle8(1'b1, 8'hE7, 8'h7E, 1'b0, acc);
        check("pre_rst_buffered", 64'(q.size()), 64'(2));
        do_reset();
        repeat (3) cycle8(1'b0, 8'($urandom), 8'($urandom), 1'b1, acc);

        // Idle with toggling operands
        for (int t = 0; t < 10; t++)
            cycle8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), acc);

        // Randomized traffic
        for (int t = 0; t < 400; t++)
            cycle8(($urandom % 4) != 0, 8'($urandom), 8'($urandom), ($urandom % 3) != 0, acc);
        for (int t = 0; t < 10 && q.size() > 0; t++)
            cycle8(1'b0, 8'h00, 8'h00, 1'b1, acc);
        check("drained", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Clocked, parameterised bitwise AND unit: C = A & B across WIDTH bits, with reduction flags on the result.
- Operands enter through a valid/ready input port. Results leave through a registered valid/ready output stage with a 2-entry skid buffer, so the block sits between pipelined datapath stages.
- WIDTH=1 gives a registered 2-input AND gate.

Parameters:
- WIDTH, 1, operand/result bit width (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- in_valid  input  1  A/B valid this cycle
- in_ready  output  1  block can accept A/B this cycle
- C  output  WIDTH  registered A & B
- C_all  output  1  &C (all result bits 1)
- C_any  output  1  |C (any result bit 1)
- out_valid  output  1  C/C_all/C_any valid
- out_ready  input  1  downstream accepts output

Behaviour:
- Accept: in_valid && in_ready at a rising edge. Emit: out_valid && out_ready at a rising edge.
- Reset (rst=1 at an edge):
  - out_valid=0, C=0, C_all=0, C_any=0, buffer emptied.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst falls.
- Latency: an accepted operand pair appears on C at the next rising edge with out_valid=1. Throughput is 1 pair/cycle while out_ready=1.
- Arithmetic: C = A & B bitwise, no width growth. C_all and C_any are computed from the same AND result, stored with it, and valid exactly when out_valid=1.
- Skid buffer: output register plus one skid register.
  - in_ready = NOT(skid occupied). This is registered, with no combinational path from out_ready.
  - Accept while output register full and not draining: pair goes to the skid register.
  - When the output drains and the skid is occupied: skid moves to the output register in that same edge. A simultaneous new accept is then not possible because in_ready was 0.
- Simultaneous accept and emit with an empty skid: output register reloads with the new result, out_valid stays 1.
- Output hold: while out_valid=1 and out_ready=0, C/C_all/C_any/out_valid are held stable.
- in_valid=0: nothing accepted, A/B ignored.
- X-safety: A/B are don't-care when in_valid=0. Outputs are don't-care when out_valid=0 but are driven to 0 after reset.
- Ordering: results are emitted in acceptance order. No drop, no duplication.
- Reset mid-operation: all buffered results are discarded and no output handshake completes on the reset edge.

Decomposition:
- Package and_gate_pkg: localparam SKID_DEPTH=2 and a function and_reduce_flags(WIDTH-bit) returning {all,any}.
- One sub-module, and_gate_skid: a generic WIDTH+2-bit valid/ready 2-entry skid buffer.
- The top computes the AND and flags combinationally on input and feeds and_gate_skid.

Test Plan:
- WIDTH=1 truth table, out_ready=1: (A,B)=(0,0),(1,0),(0,1),(1,1), one per cycle with in_valid=1 -> C=0,0,0,1 each one edge later. C_all=C_any=C. out_valid=1 each cycle.
- WIDTH=8, A=8'hF0, B=8'h3C -> C=8'h30, C_all=0, C_any=1. A=B=8'hFF -> C=8'hFF, C_all=1. A=8'hAA, B=8'h55 -> C=8'h00, C_any=0.
- Backpressure: stream 4 pairs with out_ready=0 -> first result held on C, in_ready falls to 0 after the 2nd accept. Raise out_ready -> all 4 results emitted in order, none lost.
- Simultaneous accept/emit: continuous in_valid with out_ready=1 -> one result per cycle, in_ready stays 1.
- Reset mid-stream: rst=1 with 2 results buffered -> at next edge out_valid=0, C=0, in_ready=0. After rst falls, in_ready=1 and no stale result appears.
- Idle: in_valid=0 with A/B toggling -> out_valid stays 0, C unchanged.
